cordic_seq_shifter: RTL and testbench

- Parametrised, single-clock successor to the CORDIC iteration shifter.
- Shifts a WIDTH-bit operand by a run-time amount, one bit per clock, under a start/done handshake.
- Supports arithmetic-right, logical-right and logical-left modes.
- Feeds the CORDIC x/y datapath. It replaces the divided-clock shifter, so all flops run on clk with no derived clocks.

---
 rtl/cordic_seq_shifter.sv | 118 +++++++++++
 tb/tb_cordic_seq_shifter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_shifter.sv
// rtl/cordic_seq_shifter.sv - bit-serial CORDIC operand shifter with start/done handshake
// Optional rounding of right shifts: define CORDIC_SHIFT_ROUND_EN.
module cordic_seq_shifter #(
    parameter int WIDTH = 17,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_load;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] last_value;
    logic             right_mode;

    assign right_mode = (mode_q != 2'b10);

    // Oversized requests saturate at WIDTH so latency stays bounded.
    always_comb begin
        if (int'(shamt) >= WIDTH) begin
            count_load = CW'(WIDTH);
        end else begin
            count_load = CW'(shamt);
        end
    end

    always_comb begin
        case (mode_q)
            2'b10:   shifted = {sr_q[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, sr_q[WIDTH-1:1]};
            default: shifted = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
        endcase
    end

`ifdef CORDIC_SHIFT_ROUND_EN
    logic guard_q, guard_d;

    assign guard_d    = right_mode ? sr_q[0] : 1'b0;
    // The final edge adds the bit it shifts out: round half up, no extra cycle.
    assign last_value = shifted + {{(WIDTH-1){1'b0}}, guard_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            guard_q <= guard_d;
        end
    end
`else
    assign last_value = shifted;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        count_d = count_q;
        case (state_q)
            SHIFT: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    sr_d    = last_value;
                    state_d = DONE;
                end else begin
                    sr_d = shifted;
                end
            end
            default: begin
                if (start) begin
                    sr_d    = din;
                    mode_d  = mode;
                    count_d = count_load;
                    state_d = (count_load == '0) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            mode_q  <= 2'b00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign dout = sr_q;

endmodule

// File: tb/tb_cordic_seq_shifter.sv
// tb/tb_cordic_seq_shifter.sv - scoreboard bench for cordic_seq_shifter
module tb_cordic_seq_shifter;

    localparam int W = 17;
    localparam int S = 5;
`ifdef CORDIC_SHIFT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [S-1:0] shamt = '0;
    logic [W-1:0] din = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [W-1:0] dout;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cordic_seq_shifter #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .shamt (shamt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] m, input int s, input logic [W-1:0] d);
        int               n;
        logic signed [W-1:0] sd;
        logic [W-1:0]     r;
        n  = (s > W) ? W : s;
        sd = d;
        case (m)
            2'b10:   r = d << n;
            2'b01:   r = d >> n;
            default: r = W'(sd >>> n);
        endcase
        if (RND && m != 2'b10 && n > 0) r = r + W'(d[n-1]);
        return r;
    endfunction

    // Called at a negedge: drives an operation and records its expected outcome.
    task automatic launch(input logic [1:0] m, input int s, input logic [W-1:0] d, input logic [W-1:0] e);
        exp_t x;
        mode  = m;
        shamt = S'(s);
        din   = d;
        start = 1'b1;
        x.dout = e;
        x.lat  = ((s > W) ? W : s) + 1;
        sb.push_back(x);
    endtask

    task automatic wait_done(input bit hold, input bit poke);
        int   cyc;
        int   nbusy;
        exp_t x;
        nbusy = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 64) begin
            if (busy) nbusy++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                din   = ~din;
                shamt = '0;
                mode  = 2'b10;
            end
            if (poke && cyc == 3) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", cyc, x.lat);
        chk("busy_cycles", nbusy, x.lat - 1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("dout", {15'd0, dout}, {15'd0, x.dout});
    endtask

    task automatic idle_check(input logic [W-1:0] e);
        @(negedge clk);
        chk("done_pulse_width", {31'd0, done}, 32'd0);
        chk("dout_hold", {15'd0, dout}, {15'd0, e});
    endtask

    initial begin
        logic [1:0]   rm;
        int           rs;
        logic [W-1:0] rd;

        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout", {15'd0, dout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        launch(2'b00, 3, 17'h1FC18, 17'h1FF83);
        wait_done(1'b0, 1'b0);
        idle_check(17'h1FF83);

        launch(2'b00, 0, 17'h0ABCD, 17'h0ABCD);
        wait_done(1'b0, 1'b0);

        launch(2'b00, 31, 17'h10001, RND ? 17'h00000 : 17'h1FFFF);
        wait_done(1'b0, 1'b0);
        launch(2'b01, 31, 17'h10001, RND ? 17'h00001 : 17'h00000);
        wait_done(1'b0, 1'b0);
        launch(2'b10, 4, 17'h00005, 17'h00050);
        wait_done(1'b0, 1'b0);
        launch(2'b11, 3, 17'h1FC18, 17'h1FF83);
        wait_done(1'b0, 1'b0);

        launch(2'b01, 6, 17'h0F0F0, RND ? 17'h003C4 : 17'h003C3);
        wait_done(1'b0, 1'b1);
        idle_check(RND ? 17'h003C4 : 17'h003C3);

        launch(2'b10, 3, 17'h00001, 17'h00008);
        wait_done(1'b1, 1'b0);
        launch(2'b01, 2, 17'h00010, 17'h00004);
        wait_done(1'b0, 1'b0);

        launch(2'b00, 10, 17'h12345, 17'h0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_dout", {15'd0, dout}, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        launch(2'b00, 5, 17'h00100, 17'h00008);
        wait_done(1'b0, 1'b0);

        launch(2'b00, 1, 17'h00007, RND ? 17'h00004 : 17'h00003);
        wait_done(1'b0, 1'b0);
        launch(2'b00, 1, 17'h1FFF9, RND ? 17'h1FFFD : 17'h1FFFC);
        wait_done(1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rm = 2'($urandom_range(0, 3));
            rs = int'($urandom_range(0, 31));
            rd = W'($urandom);
            launch(rm, rs, rd, model(rm, rs, rd));
            wait_done(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
